pgm_ddram_arbiter: RTL and testbench
====================================

// Module: pgm_ddram_arbiter
// PURPOSE
//  Shares the single DDRAM port between three requesters:
//   - ROM download writer (ioctl, 64-bit packed words)
//   - video tile fetch (read client 0)
//   - sprite fetch (read client 1)
//  One transaction in flight at a time. Single-beat bursts only. Client word addresses are offset by a fixed base.
//  Sits between the PGM core / pgm_video and the DDRAM pins of emu.
// PARAMETERS
//  BASE_WORD  29'h0600_0000  64-bit word offset added to every client address (byte 0x3000_0000)
// PORTS
//  clk             in   1   system clock; also drives ddram_clk
//  reset_n         in   1   asynchronous, active-low reset
//  wr_req          in   1   writer request; level, held until wr_ack
//  wr_addr         in   29  writer 64-bit word address, relative to BASE_WORD
//  wr_data         in   64  write data
//  wr_be           in   8   write byte enables
//  wr_ack          out  1   1-cycle pulse: write accepted by DDRAM
//  rd_req[1:0]     in   2   read requests, per client; level, held until rd_valid
//  rd_addr0/1      in   29  read word address per client, relative to BASE_WORD
//  rd_data         out  64  read data, shared by both clients
//  rd_valid[1:0]   out  2   1-cycle pulse to the owning client: rd_data valid
//  ddram_clk       out  1   = clk
//  ddram_addr      out  29  DDRAM word address
//  ddram_burstcnt  out  4   constant 4'd1
//  ddram_busy      in   1   DDRAM not accepting commands
//  ddram_rd        out  1   read command
//  ddram_we        out  1   write command
//  ddram_din       out  64  write data
//  ddram_be        out  8   write byte enables
//  ddram_dout      in   64  read data
//  ddram_dout_ready in  1   read data valid
// BEHAVIOUR
//  Reset values: wr_ack=0, rd_valid=0, rd_data=0, ddram_rd=0, ddram_we=0, ddram_addr=0, ddram_din=0, ddram_be=0, last_grant=1, state=IDLE.
//  Mid-operation reset: aborts to IDLE. No ack or valid is emitted for the aborted transaction.
//  All outputs are registered.
//  Address: ddram_addr = (BASE_WORD + client_addr) mod 2^29. Wrap is silent.
//  Command rule: a command is accepted on a cycle where ddram_rd or ddram_we = 1 and ddram_busy = 0. Until then, command, addr, din and be are held stable.
//  FSM:
//   IDLE  -> WRITE if wr_req. The writer has absolute priority over reads.
//         -> READ if any rd_req. With both requesting, grant the client != last_grant (round-robin).
//         -> On leaving IDLE, latch addr/data and assert the command on the next edge.
//         -> Arbitration decision to command: 1 cycle.
//   WRITE -> on accept: ddram_we<=0, wr_ack pulses next cycle, -> IDLE.
//   READ  -> on accept: ddram_rd<=0, -> RWAIT. last_grant <= granted client.
//   RWAIT -> on ddram_dout_ready: rd_data<=ddram_dout, rd_valid[g] pulses next cycle, -> IDLE.
//  dout_ready outside RWAIT is ignored.
//  A request is re-arbitrated no earlier than the cycle after its ack/valid pulse. Requesters must drop req in the ack cycle or they are served again.
//  Minimum turnaround IDLE->IDLE, busy=0: write 3 cycles; read 3 cycles + DDRAM latency.
//  Request dropped before grant: no effect. Request dropped after grant: the transaction still completes and acks.
//  rd_req and wr_req are sampled only in IDLE. Address and data changes while granted are ignored; the latched copies are used.
// TESTING
//  1. Reset held, all reqs=1 -> all commands 0, no pulses. Release: write granted first; ddram_we=1, addr=0x0600_0000+wr_addr.
//  2. wr_req with wr_addr=0x10, busy=1 for 5 cycles -> we/addr/din held stable 5 cycles. wr_ack exactly once, 1 cycle after accept.
//  3. rd_req=2'b11 held, ack each -> grants alternate 0,1,0,1. rd_data equals the model memory value.
//  4. wr_req and rd_req[0] in the same cycle -> write completes first, then read 0. No overlap of rd/we.
//  5. rd_addr0=29'h1FFF_FFFF, BASE_WORD=0x0600_0000 -> ddram_addr=29'h05FF_FFFF (wrap).
//  6. reset_n low while in RWAIT -> IDLE, no rd_valid. Stray dout_ready in IDLE -> ignored.

Source files
------------

// File: rtl/pgm_ddram_arbiter_if.sv
// pgm_ddram_arbiter_if: client and DDRAM bus bundle for the PGM DDRAM arbiter
//   slave  : arbiter view (takes client requests, drives DDRAM commands)
//   master : environment view (clients + DDRAM controller)
//   wr_*            ROM download writer: level req, word addr, data, byte enables, ack pulse
//   rd_*            two read clients: level req[1:0], word addrs, shared data, per-client valid pulse
//   ddram_*         single-beat DDRAM command/data port
interface pgm_ddram_arbiter_if;
    logic        wr_req;
    logic [28:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic        wr_ack;
    logic [1:0]  rd_req;
    logic [28:0] rd_addr0;
    logic [28:0] rd_addr1;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic [28:0] ddram_addr;
    logic [3:0]  ddram_burstcnt;
    logic        ddram_busy;
    logic        ddram_rd;
    logic        ddram_we;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
    logic [63:0] ddram_dout;
    logic        ddram_dout_ready;

    modport slave (
        input  wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr0, rd_addr1,
               ddram_busy, ddram_dout, ddram_dout_ready,
        output wr_ack, rd_data, rd_valid, ddram_addr, ddram_burstcnt,
               ddram_rd, ddram_we, ddram_din, ddram_be
    );

    modport master (
        output wr_req, wr_addr, wr_data, wr_be, rd_req, rd_addr0, rd_addr1,
               ddram_busy, ddram_dout, ddram_dout_ready,
        input  wr_ack, rd_data, rd_valid, ddram_addr, ddram_burstcnt,
               ddram_rd, ddram_we, ddram_din, ddram_be
    );
endinterface

// File: rtl/pgm_ddram_arbiter.sv
// pgm_ddram_arbiter: shares one DDRAM port between the ROM writer and two read clients
//   clk        system clock, forwarded as ddram_clk
//   reset_n    asynchronous active-low reset
//   ddram_clk  copy of clk for the DDRAM port
//   bus        client/DDRAM bundle (slave modport)
// One single-beat transaction in flight; the writer beats the readers, readers round-robin.
module pgm_ddram_arbiter #(
    parameter logic [28:0] BASE_WORD = 29'h0600_0000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic                        ddram_clk,
    pgm_ddram_arbiter_if.slave          bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RWAIT} state_t;

    state_t state;
    logic   gnt;
    logic   last_grant;
    logic   pick;

    assign ddram_clk          = clk;
    assign bus.ddram_burstcnt = 4'd1;

    // with both readers asking, serve the one that did not go last
    assign pick = (bus.rd_req == 2'b11) ? ~last_grant : bus.rd_req[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            gnt            <= 1'b0;
            last_grant     <= 1'b1;
            bus.wr_ack     <= 1'b0;
            bus.rd_valid   <= 2'b00;
            bus.rd_data    <= '0;
            bus.ddram_rd   <= 1'b0;
            bus.ddram_we   <= 1'b0;
            bus.ddram_addr <= '0;
            bus.ddram_din  <= '0;
            bus.ddram_be   <= '0;
        end else begin
            bus.wr_ack   <= 1'b0;
            bus.rd_valid <= 2'b00;
            case (state)
                // no arbitration while an ack/valid is out, so the served
                // requester gets that cycle to drop its request
                IDLE: if (!(bus.wr_ack || |bus.rd_valid)) begin
                    if (bus.wr_req) begin
                        state          <= WRITE;
                        bus.ddram_we   <= 1'b1;
                        bus.ddram_addr <= BASE_WORD + bus.wr_addr;
                        bus.ddram_din  <= bus.wr_data;
                        bus.ddram_be   <= bus.wr_be;
                    end else if (|bus.rd_req) begin
                        state          <= READ;
                        gnt            <= pick;
                        bus.ddram_rd   <= 1'b1;
                        bus.ddram_addr <= BASE_WORD + (pick ? bus.rd_addr1 : bus.rd_addr0);
                    end
                end
                WRITE: if (!bus.ddram_busy) begin
                    bus.ddram_we <= 1'b0;
                    bus.wr_ack   <= 1'b1;
                    state        <= IDLE;
                end
                READ: if (!bus.ddram_busy) begin
                    bus.ddram_rd <= 1'b0;
                    last_grant   <= gnt;
                    state        <= RWAIT;
                end
                RWAIT: if (bus.ddram_dout_ready) begin
                    bus.rd_data  <= bus.ddram_dout;
                    bus.rd_valid <= gnt ? 2'b10 : 2'b01;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
// tb_pgm_ddram_arbiter: directed, table-driven bench for pgm_ddram_arbiter
module tb_pgm_ddram_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ddram_clk;
    int   tests = 0;
    int   fails = 0;
    int   overlap = 0;

    always #5 clk = ~clk;

    pgm_ddram_arbiter_if bus();

    pgm_ddram_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ddram_clk (ddram_clk),
        .bus       (bus)
    );

    typedef struct {
        bit          wr;
        logic [28:0] a0;
        logic [28:0] a1;
        logic [1:0]  rq;
        logic [63:0] d;
        logic [7:0]  be;
        int          busy;
        int          lat;
        logic [28:0] ea;
        logic [1:0]  rv;
        bit          keep;
    } vec_t;

    vec_t v[10];
    vec_t x;

    function automatic logic [63:0] mem(input logic [28:0] a);
        return {3'b101, a, 3'b011, ~a};
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) if (bus.ddram_we && bus.ddram_rd) overlap++;

    task automatic run(input vec_t t);
        int n;
        logic [28:0] a;
        if (t.wr) begin
            bus.wr_req = 1'b1; bus.wr_addr = t.a0; bus.wr_data = t.d; bus.wr_be = t.be;
        end else begin
            bus.rd_req = t.rq; bus.rd_addr0 = t.a0; bus.rd_addr1 = t.a1;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.ddram_we || bus.ddram_rd) && n < 10);
        chk("cmd_timeout", 64'(n < 10), 64'd1);
        chk(t.wr ? "cmd_we" : "cmd_rd", {bus.ddram_we, bus.ddram_rd}, t.wr ? 2'b10 : 2'b01);
        chk("addr", bus.ddram_addr, t.ea);
        if (t.wr) begin
            chk("din", bus.ddram_din, t.d);
            chk("be", bus.ddram_be, t.be);
        end
        a = bus.ddram_addr;
        // scramble client inputs: the latched copies must stay on the bus
        bus.wr_addr = ~t.a0; bus.wr_data = ~t.d; bus.wr_be = ~t.be;
        bus.rd_addr0 = ~t.a0; bus.rd_addr1 = ~t.a1;
        bus.ddram_busy = (t.busy > 0);
        for (int i = 0; i < t.busy; i++) begin
            @(negedge clk);
            chk("hold_cmd", {bus.ddram_we, bus.ddram_rd}, t.wr ? 2'b10 : 2'b01);
            chk("hold_addr", bus.ddram_addr, t.ea);
            if (t.wr) chk("hold_din", {bus.ddram_din, bus.ddram_be, bus.wr_ack}, {t.d, t.be, 1'b0});
        end
        bus.ddram_busy = 1'b0;
        @(negedge clk);
        if (t.wr) begin
            chk("wr_ack", bus.wr_ack, 1'b1);
            chk("we_drop", bus.ddram_we, 1'b0);
            bus.wr_req = 1'b0;
            @(negedge clk);
            chk("wr_ack_pulse", bus.wr_ack, 1'b0);
        end else begin
            chk("rd_drop", bus.ddram_rd, 1'b0);
            for (int i = 0; i < t.lat; i++) begin
                @(negedge clk);
                chk("early_valid", bus.rd_valid, 2'b00);
            end
            bus.ddram_dout = mem(a);
            bus.ddram_dout_ready = 1'b1;
            @(negedge clk);
            bus.ddram_dout_ready = 1'b0;
            chk("rd_valid", bus.rd_valid, t.rv);
            chk("rd_data", bus.rd_data, mem(t.ea));
            if (!t.keep) bus.rd_req = 2'b00;
            @(negedge clk);
            chk("rd_valid_pulse", bus.rd_valid, 2'b00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //      wr  a0            a1           rq     d                      be     busy lat ea            rv     keep
        v[0] = '{1, 29'h10,       29'h0,       2'b00, 64'h1122334455667788, 8'hF0, 5,   0,  29'h0600_0010, 2'b00, 0};
        v[1] = '{1, 29'h1FFF_FFFF,29'h0,       2'b00, 64'hCAFEF00DDEADBEEF, 8'hFF, 0,   0,  29'h05FF_FFFF, 2'b00, 0};
        v[2] = '{0, 29'h20,       29'h0,       2'b01, 64'h0,                8'h00, 0,   2,  29'h0600_0020, 2'b01, 0};
        v[3] = '{0, 29'h0,        29'h30,      2'b10, 64'h0,                8'h00, 1,   0,  29'h0600_0030, 2'b10, 0};
        v[4] = '{0, 29'h100,      29'h200,     2'b11, 64'h0,                8'h00, 0,   1,  29'h0600_0100, 2'b01, 1};
        v[5] = '{0, 29'h100,      29'h200,     2'b11, 64'h0,                8'h00, 0,   1,  29'h0600_0200, 2'b10, 1};
        v[6] = '{0, 29'h100,      29'h200,     2'b11, 64'h0,                8'h00, 1,   0,  29'h0600_0100, 2'b01, 1};
        v[7] = '{0, 29'h100,      29'h200,     2'b11, 64'h0,                8'h00, 0,   2,  29'h0600_0200, 2'b10, 0};
        v[8] = '{0, 29'h1FFF_FFFF,29'h0,       2'b01, 64'h0,                8'h00, 2,   3,  29'h05FF_FFFF, 2'b01, 0};
        v[9] = '{1, 29'h0,        29'h0,       2'b00, 64'h0123456789ABCDEF, 8'h01, 1,   0,  29'h0600_0000, 2'b00, 0};

        bus.wr_req = 1'b1; bus.wr_addr = 29'h5; bus.wr_data = 64'hA5A5_5A5A_0F0F_F0F0; bus.wr_be = 8'h3C;
        bus.rd_req = 2'b11; bus.rd_addr0 = 29'h7; bus.rd_addr1 = 29'h9;
        bus.ddram_busy = 1'b0; bus.ddram_dout = '0; bus.ddram_dout_ready = 1'b0;

        // reset held with every request up: nothing moves
        repeat (3) begin
            @(negedge clk);
            chk("rst_cmds", {bus.ddram_we, bus.ddram_rd, bus.wr_ack, bus.rd_valid}, 5'b0);
            chk("rst_regs", {bus.ddram_addr, bus.ddram_be, bus.ddram_din, bus.rd_data}, '0);
        end
        chk("burstcnt", bus.ddram_burstcnt, 4'd1);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_we_first", {bus.ddram_we, bus.ddram_rd}, 2'b10);
        chk("rel_addr", bus.ddram_addr, 29'h0600_0005);
        chk("rel_din", bus.ddram_din, 64'hA5A5_5A5A_0F0F_F0F0);
        @(negedge clk);
        chk("rel_ack", {bus.wr_ack, bus.ddram_we}, 2'b10);
        bus.wr_req = 1'b0; bus.rd_req = 2'b00;
        @(negedge clk);
        chk("rel_quiet", {bus.wr_ack, bus.ddram_we, bus.ddram_rd}, 3'b000);

        for (int i = 0; i < 10; i++) run(v[i]);

        // write and read 0 arrive together: write first, then read
        bus.wr_req = 1'b1; bus.wr_addr = 29'h44; bus.wr_data = 64'h5555; bus.wr_be = 8'hAA;
        bus.rd_req = 2'b01; bus.rd_addr0 = 29'h55;
        @(negedge clk);
        chk("sim_we", {bus.ddram_we, bus.ddram_rd}, 2'b10);
        chk("sim_waddr", bus.ddram_addr, 29'h0600_0044);
        @(negedge clk);
        chk("sim_ack", {bus.wr_ack, bus.ddram_we, bus.ddram_rd}, 3'b100);
        bus.wr_req = 1'b0;
        @(negedge clk);
        chk("sim_gap", {bus.ddram_we, bus.ddram_rd}, 2'b00);
        @(negedge clk);
        chk("sim_rd", {bus.ddram_we, bus.ddram_rd}, 2'b01);
        chk("sim_raddr", bus.ddram_addr, 29'h0600_0055);
        @(negedge clk);
        chk("sim_rd_acc", bus.ddram_rd, 1'b0);
        bus.ddram_dout = 64'hFEED_FACE_1234_5678; bus.ddram_dout_ready = 1'b1;
        @(negedge clk);
        bus.ddram_dout_ready = 1'b0;
        chk("sim_valid", bus.rd_valid, 2'b01);
        chk("sim_data", bus.rd_data, 64'hFEED_FACE_1234_5678);
        bus.rd_req = 2'b00;
        @(negedge clk);

        // reset during RWAIT, then a stray dout_ready while idle
        bus.rd_req = 2'b10; bus.rd_addr1 = 29'h40;
        @(negedge clk);
        chk("rw_rd", {bus.ddram_rd, bus.ddram_addr}, {1'b1, 29'h0600_0040});
        @(negedge clk);
        chk("rw_acc", bus.ddram_rd, 1'b0);
        reset_n = 1'b0; bus.rd_req = 2'b00;
        @(negedge clk);
        chk("rw_no_valid", bus.rd_valid, 2'b00);
        reset_n = 1'b1; bus.ddram_dout = 64'hDEAD_BEEF_DEAD_BEEF; bus.ddram_dout_ready = 1'b1;
        @(negedge clk);
        bus.ddram_dout_ready = 1'b0;
        @(negedge clk);
        chk("stray_valid", bus.rd_valid, 2'b00);
        chk("stray_data", bus.rd_data, 64'h0);
        chk("stray_cmd", {bus.ddram_we, bus.ddram_rd}, 2'b00);

        // reset restores last_grant=1, so a contested read goes to client 0
        x = '{0, 29'h100, 29'h200, 2'b11, 64'h0, 8'h00, 0, 1, 29'h0600_0100, 2'b01, 0};
        run(x);

        chk("no_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
